// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the fetch/data memory arbiter.
// The CPU top level imports the state encoding and abort read value from here.
package mem_arbiter_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned WAIT_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } arb_state_e;

    // Read data returned to a requester whose memory access timed out.
    localparam logic [DATA_W-1:0] ABORT_RDATA = '0;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_cmd_t;

    // Round-robin pick: 1 selects data. On contention the side not granted last wins.
    function automatic logic pick_data(input logic i_elig, input logic d_elig,
                                       input logic last_was_data);
        return d_elig & (~i_elig | ~last_was_data);
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one memory port,
// with round-robin on contention and an m_ack timeout that aborts and flags err.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_ack,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              err_clr,
    output logic              err,
    output logic              stall
);

    arb_state_e        state;
    logic              last_data;
    mem_cmd_t          cmd_q;
    logic [WAIT_W-1:0] wait_cnt;

    logic              i_elig_c;
    logic              d_elig_c;
    logic              grant_data_c;
    logic              timeout_c;
    logic [DATA_W-1:0] rsp_data_c;

    // A requester whose ack is high this cycle is finishing, not asking again.
    assign i_elig_c     = i_req & ~i_ack;
    assign d_elig_c     = d_req & ~d_ack;
    assign grant_data_c = pick_data(i_elig_c, d_elig_c, last_data);
    assign stall        = i_elig_c | d_elig_c;

    assign timeout_c  = (state != IDLE) && !m_ack && (wait_cnt == WAIT_W'(TIMEOUT - 1));
    assign rsp_data_c = (m_ack && !cmd_q.we) ? m_rdata : ABORT_RDATA;

    assign m_we    = cmd_q.we;
    assign m_addr  = cmd_q.addr;
    assign m_wdata = cmd_q.wdata;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            last_data <= 1'b1;
            cmd_q     <= '0;
            wait_cnt  <= '0;
            m_req     <= 1'b0;
            i_ack     <= 1'b0;
            d_ack     <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            err       <= 1'b0;
        end else begin
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            if (err_clr) begin
                err <= 1'b0;
            end
            unique case (state)
                IDLE: begin
                    if (i_elig_c || d_elig_c) begin
                        wait_cnt  <= '0;
                        m_req     <= 1'b1;
                        last_data <= grant_data_c;
                        if (grant_data_c) begin
                            state       <= GNT_D;
                            cmd_q.we    <= d_we;
                            cmd_q.addr  <= d_addr;
                            cmd_q.wdata <= d_wdata;
                        end else begin
                            state       <= GNT_I;
                            cmd_q.we    <= 1'b0;
                            cmd_q.addr  <= i_addr;
                            cmd_q.wdata <= '0;
                        end
                    end
                end
                GNT_I, GNT_D: begin
                    if (m_ack || timeout_c) begin
                        state <= IDLE;
                        m_req <= 1'b0;
                        if (state == GNT_I) begin
                            i_ack   <= 1'b1;
                            i_rdata <= rsp_data_c;
                        end else begin
                            d_ack   <= 1'b1;
                            d_rdata <= rsp_data_c;
                        end
                        // Timeout wins over a simultaneous err_clr.
                        if (timeout_c) begin
                            err <= 1'b1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    m_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
